// File: rtl/cmd_sequencer.sv
// SD CMD-line sequencer: arbitrates host/auto commands, runs the cmd_write
// start/done handshake, arms the response receiver and enforces Ncr / Ncc timing.
module cmd_sequencer #(
  parameter int unsigned RspTimeout = 64,
  parameter int unsigned NccTicks   = 8,
  parameter int unsigned CntWidth   = 7
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clk_en_p_i,
  input  logic        abort_i,
  input  logic        host_req_i,
  input  logic [5:0]  host_cmd_nr_i,
  input  logic [31:0] host_arg_i,
  input  logic [1:0]  host_rsp_type_i,
  input  logic        auto_req_i,
  input  logic [5:0]  auto_cmd_nr_i,
  input  logic [31:0] auto_arg_i,
  input  logic [1:0]  auto_rsp_type_i,
  output logic        host_grant_o,
  output logic        auto_grant_o,
  output logic        start_tx_o,
  output logic [5:0]  cmd_nr_o,
  output logic [31:0] cmd_argument_o,
  input  logic        tx_done_i,
  output logic        rsp_arm_o,
  output logic        rsp_long_o,
  input  logic        rsp_done_i,
  input  logic        rsp_crc_err_i,
  input  logic        rsp_end_err_i,
  input  logic [5:0]  rsp_index_i,
  output logic        cmd_inhibit_o,
  output logic        active_auto_o,
  output logic        cmd_done_o,
  output logic        timeout_err_o,
  output logic        crc_err_o,
  output logic        end_err_o,
  output logic        index_err_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    TX,
    WAIT_RSP,
    GAP
  } state_e;

  localparam logic [CntWidth-1:0] RspLimit = CntWidth'(RspTimeout);
  localparam logic [CntWidth-1:0] NccLimit = CntWidth'(NccTicks);

  state_e              state_q;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_inc;
  logic [1:0]          rsp_type_q;

  // The tick counter is shared by the Ncr and Ncc phases and must never wrap.
  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

  assign cnt_inc = sat_inc(cnt_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rsp_type_q     <= '0;
      host_grant_o   <= 1'b0;
      auto_grant_o   <= 1'b0;
      start_tx_o     <= 1'b0;
      cmd_nr_o       <= '0;
      cmd_argument_o <= '0;
      rsp_arm_o      <= 1'b0;
      rsp_long_o     <= 1'b0;
      cmd_inhibit_o  <= 1'b0;
      active_auto_o  <= 1'b0;
      cmd_done_o     <= 1'b0;
      timeout_err_o  <= 1'b0;
      crc_err_o      <= 1'b0;
      end_err_o      <= 1'b0;
      index_err_o    <= 1'b0;
    end else begin
      host_grant_o  <= 1'b0;
      auto_grant_o  <= 1'b0;
      cmd_done_o    <= 1'b0;
      timeout_err_o <= 1'b0;
      crc_err_o     <= 1'b0;
      end_err_o     <= 1'b0;
      index_err_o   <= 1'b0;

      if (abort_i) begin
        state_q        <= IDLE;
        cnt_q          <= '0;
        rsp_type_q     <= '0;
        start_tx_o     <= 1'b0;
        cmd_nr_o       <= '0;
        cmd_argument_o <= '0;
        rsp_arm_o      <= 1'b0;
        rsp_long_o     <= 1'b0;
        cmd_inhibit_o  <= 1'b0;
        active_auto_o  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // Auto command (e.g. CMD12) takes precedence over a pending host command.
            if (auto_req_i || host_req_i) begin
              cmd_nr_o       <= auto_req_i ? auto_cmd_nr_i   : host_cmd_nr_i;
              cmd_argument_o <= auto_req_i ? auto_arg_i      : host_arg_i;
              rsp_type_q     <= auto_req_i ? auto_rsp_type_i : host_rsp_type_i;
              auto_grant_o   <= auto_req_i;
              host_grant_o   <= !auto_req_i;
              active_auto_o  <= auto_req_i;
              cmd_inhibit_o  <= 1'b1;
              start_tx_o     <= 1'b1;
              state_q        <= START;
            end
          end

          START: begin
            if (!tx_done_i) begin
              start_tx_o <= 1'b0;
              state_q    <= TX;
            end
          end

          TX: begin
            if (tx_done_i) begin
              cnt_q <= '0;
              if (rsp_type_q == 2'b00) begin
                cmd_done_o <= 1'b1;
                state_q    <= GAP;
              end else begin
                rsp_arm_o  <= 1'b1;
                rsp_long_o <= (rsp_type_q == 2'b01);
                state_q    <= WAIT_RSP;
              end
            end
          end

          WAIT_RSP: begin
            // A response landing on the timeout tick still counts as a response.
            if (rsp_done_i) begin
              cmd_done_o  <= 1'b1;
              crc_err_o   <= rsp_crc_err_i;
              end_err_o   <= rsp_end_err_i;
              index_err_o <= (rsp_type_q != 2'b01) && (rsp_index_i != cmd_nr_o);
              rsp_arm_o   <= 1'b0;
              rsp_long_o  <= 1'b0;
              cnt_q       <= '0;
              state_q     <= GAP;
            end else if (clk_en_p_i) begin
              cnt_q <= cnt_inc;
              if (cnt_inc >= RspLimit) begin
                cmd_done_o    <= 1'b1;
                timeout_err_o <= 1'b1;
                rsp_arm_o     <= 1'b0;
                rsp_long_o    <= 1'b0;
                cnt_q         <= '0;
                state_q       <= GAP;
              end
            end
          end

          GAP: begin
            if (clk_en_p_i) begin
              cnt_q <= cnt_inc;
              if (cnt_inc >= NccLimit) begin
                cmd_inhibit_o <= 1'b0;
                active_auto_o <= 1'b0;
                state_q       <= IDLE;
              end
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Randomized bench for cmd_sequencer: plays cmd_write and the response receiver,
// predicting grants, status flags and tick timing from the command-level rules.
module tb_cmd_sequencer;

  localparam int NPAT   = 65536;
  localparam int RSP_TO = 64;
  localparam int NCC    = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clk_en_p_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        host_req_i = 1'b0;
  logic [5:0]  host_cmd_nr_i = '0;
  logic [31:0] host_arg_i = '0;
  logic [1:0]  host_rsp_type_i = '0;
  logic        auto_req_i = 1'b0;
  logic [5:0]  auto_cmd_nr_i = '0;
  logic [31:0] auto_arg_i = '0;
  logic [1:0]  auto_rsp_type_i = '0;
  logic        host_grant_o, auto_grant_o, start_tx_o;
  logic [5:0]  cmd_nr_o;
  logic [31:0] cmd_argument_o;
  logic        tx_done_i = 1'b1;
  logic        rsp_arm_o, rsp_long_o;
  logic        rsp_done_i = 1'b0;
  logic        rsp_crc_err_i = 1'b0;
  logic        rsp_end_err_i = 1'b0;
  logic [5:0]  rsp_index_i = '0;
  logic        cmd_inhibit_o, active_auto_o, cmd_done_o;
  logic        timeout_err_o, crc_err_o, end_err_o, index_err_o;

  cmd_sequencer #(.RspTimeout(RSP_TO), .NccTicks(NCC), .CntWidth(7)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clk_en_p_i(clk_en_p_i), .abort_i(abort_i),
    .host_req_i(host_req_i), .host_cmd_nr_i(host_cmd_nr_i), .host_arg_i(host_arg_i),
    .host_rsp_type_i(host_rsp_type_i), .auto_req_i(auto_req_i), .auto_cmd_nr_i(auto_cmd_nr_i),
    .auto_arg_i(auto_arg_i), .auto_rsp_type_i(auto_rsp_type_i), .host_grant_o(host_grant_o),
    .auto_grant_o(auto_grant_o), .start_tx_o(start_tx_o), .cmd_nr_o(cmd_nr_o),
    .cmd_argument_o(cmd_argument_o), .tx_done_i(tx_done_i), .rsp_arm_o(rsp_arm_o),
    .rsp_long_o(rsp_long_o), .rsp_done_i(rsp_done_i), .rsp_crc_err_i(rsp_crc_err_i),
    .rsp_end_err_i(rsp_end_err_i), .rsp_index_i(rsp_index_i), .cmd_inhibit_o(cmd_inhibit_o),
    .active_auto_o(active_auto_o), .cmd_done_o(cmd_done_o), .timeout_err_o(timeout_err_o),
    .crc_err_o(crc_err_o), .end_err_o(end_err_o), .index_err_o(index_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ticks = 0;
  bit tick_pat [NPAT];
  logic prev_inh = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({host_grant_o, auto_grant_o, start_tx_o, cmd_nr_o, cmd_argument_o, rsp_arm_o,
                rsp_long_o, cmd_inhibit_o, active_auto_o, cmd_done_o, timeout_err_o,
                crc_err_o, end_err_o, index_err_o});
  endfunction

  // SD clock tick schedule: isolated one-cycle pulses 2..5 cycles apart.
  initial begin
    int p;
    p = 1;
    while (p < NPAT) begin
      tick_pat[p] = 1'b1;
      p += 2 + int'($urandom_range(3));
    end
    forever begin
      @(negedge clk);
      clk_en_p_i = tick_pat[cyc % NPAT];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clk_en_p_i) ticks <= ticks + 1;
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      if (!cmd_done_o)
        check_eq("err_quiet", {timeout_err_o, crc_err_o, end_err_o, index_err_o}, 0);
      if (host_grant_o || auto_grant_o) begin
        check_eq("grant_when_idle", prev_inh, 0);
        check_eq("grant_onehot", host_grant_o & auto_grant_o, 0);
      end
    end
    prev_inh = cmd_inhibit_o;
  end

  task automatic wait_ticks(input int n);
    int t0;
    t0 = ticks;
    for (int k = 0; k < 4000 && (ticks - t0) < n; k++) @(negedge clk);
  endtask

  task automatic wait_grant(input bit exp_auto, input logic [5:0] nr, input logic [31:0] arg,
                            output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat = k;
      if (host_grant_o || auto_grant_o) break;
    end
    check_eq("grant_seen", host_grant_o | auto_grant_o, 1);
    check_eq("grant_src", {auto_grant_o, host_grant_o}, exp_auto ? 2'b10 : 2'b01);
    check_eq("cmd_nr", cmd_nr_o, nr);
    check_eq("cmd_arg", cmd_argument_o, arg);
    check_eq("inhibit_on", cmd_inhibit_o, 1);
    check_eq("active_auto", active_auto_o, exp_auto);
    check_eq("start_tx", start_tx_o, 1);
  endtask

  // d = 0: no response (timeout expected); d = 1..64: response on the d-th tick of WAIT_RSP.
  task automatic play_cmd(input bit exp_auto, input logic [5:0] nr, input logic [1:0] typ,
                          input int f, input int len, input int d, input bit crc,
                          input bit ende, input logic [5:0] idx);
    int t0;
    int td;
    logic [3:0] exp_err;
    t0 = 0;
    wait_ticks(f);
    tx_done_i = 1'b0;
    @(negedge clk);
    check_eq("start_drop", start_tx_o, 0);
    wait_ticks(len);
    tx_done_i = 1'b1;
    @(negedge clk);
    if (typ == 2'b00) begin
      check_eq("no_arm", rsp_arm_o, 0);
      exp_err = 4'b0000;
    end else begin
      check_eq("rsp_arm", rsp_arm_o, 1);
      check_eq("rsp_long", rsp_long_o, typ == 2'b01);
      t0 = ticks;
      for (int k = 0; k < 1000; k++) begin
        rsp_done_i    = (d != 0) && tick_pat[cyc % NPAT] && (ticks - t0 + 1 == d);
        rsp_crc_err_i = crc;
        rsp_end_err_i = ende;
        rsp_index_i   = idx;
        @(negedge clk);
        if (cmd_done_o) break;
        check_eq("arm_hold", {rsp_arm_o, rsp_long_o}, {1'b1, typ == 2'b01});
      end
      rsp_done_i = 1'b0;
      check_eq("done_ticks", ticks - t0, (d != 0) ? d : RSP_TO);
      if (d == 0) exp_err = 4'b1000;
      else exp_err = {1'b0, crc, ende, (typ != 2'b01) && (idx != nr)};
    end
    check_eq("cmd_done", cmd_done_o, 1);
    check_eq("err_flags", {timeout_err_o, crc_err_o, end_err_o, index_err_o}, exp_err);
    check_eq("arm_drop", rsp_arm_o, 0);
    check_eq("gap_active_auto", active_auto_o, exp_auto);
    td = ticks;
    for (int k = 0; k < 500 && cmd_inhibit_o; k++) @(negedge clk);
    check_eq("inhibit_fall", cmd_inhibit_o, 0);
    check_eq("gap_ticks", ticks - td, NCC);
  endtask

  task automatic play_random(input bit exp_auto, input logic [5:0] nr, input logic [1:0] typ);
    int d;
    int r;
    logic [5:0] idx;
    r = int'($urandom_range(7));
    if (r == 0) d = 0;
    else if (r == 1) d = RSP_TO;
    else d = 1 + int'($urandom_range(62));
    idx = $urandom_range(1) ? nr : 6'($urandom);
    play_cmd(exp_auto, nr, typ, int'($urandom_range(3)), 1 + int'($urandom_range(7)), d,
             1'($urandom), 1'($urandom), idx);
  endtask

  initial begin
    int lat;
    int mode;
    bit saw_done;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", outs(), 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check_eq("post_reset_outs", outs(), 0);

    // Basic host command with 48-bit response.
    host_cmd_nr_i = 6'd17; host_arg_i = 32'h0000_1234; host_rsp_type_i = 2'b10; host_req_i = 1'b1;
    wait_grant(1'b0, 6'd17, 32'h0000_1234, lat);
    host_req_i = 1'b0;
    play_cmd(1'b0, 6'd17, 2'b10, 2, 48, 5, 1'b0, 1'b0, 6'd17);

    // Simultaneous requests: auto first, host right after the gap.
    auto_cmd_nr_i = 6'd12; auto_arg_i = 32'hA5A5_0001; auto_rsp_type_i = 2'b00;
    host_cmd_nr_i = 6'd5;  host_arg_i = 32'h0BAD_F00D; host_rsp_type_i = 2'b10;
    auto_req_i = 1'b1; host_req_i = 1'b1;
    wait_grant(1'b1, 6'd12, 32'hA5A5_0001, lat);
    auto_req_i = 1'b0;
    play_cmd(1'b1, 6'd12, 2'b00, 1, 3, 0, 1'b0, 1'b0, 6'd0);
    wait_grant(1'b0, 6'd5, 32'h0BAD_F00D, lat);
    check_eq("host_after_gap", lat, 0);
    host_req_i = 1'b0;
    play_cmd(1'b0, 6'd5, 2'b10, 1, 3, 7, 1'b0, 1'b1, 6'd5);

    // Timeout, response on the timeout tick, long vs short index check.
    host_cmd_nr_i = 6'd8; host_arg_i = 32'h1; host_rsp_type_i = 2'b10; host_req_i = 1'b1;
    wait_grant(1'b0, 6'd8, 32'h1, lat);
    host_req_i = 1'b0;
    play_cmd(1'b0, 6'd8, 2'b10, 0, 2, 0, 1'b0, 1'b0, 6'd8);
    host_req_i = 1'b1;
    wait_grant(1'b0, 6'd8, 32'h1, lat);
    host_req_i = 1'b0;
    play_cmd(1'b0, 6'd8, 2'b10, 1, 2, RSP_TO, 1'b1, 1'b0, 6'd8);
    host_cmd_nr_i = 6'd2; host_arg_i = 32'h2; host_rsp_type_i = 2'b01; host_req_i = 1'b1;
    wait_grant(1'b0, 6'd2, 32'h2, lat);
    host_req_i = 1'b0;
    play_cmd(1'b0, 6'd2, 2'b01, 1, 2, 10, 1'b0, 1'b0, 6'd63);
    host_rsp_type_i = 2'b10; host_req_i = 1'b1;
    wait_grant(1'b0, 6'd2, 32'h2, lat);
    host_req_i = 1'b0;
    play_cmd(1'b0, 6'd2, 2'b10, 1, 2, 10, 1'b0, 1'b0, 6'd63);

    // Randomized command mix.
    for (int i = 0; i < 25; i++) begin
      mode = int'($urandom_range(2));
      host_cmd_nr_i = 6'($urandom); host_arg_i = $urandom; host_rsp_type_i = 2'($urandom);
      auto_cmd_nr_i = 6'($urandom); auto_arg_i = $urandom; auto_rsp_type_i = 2'($urandom);
      host_req_i = (mode != 1);
      auto_req_i = (mode != 0);
      wait_grant(mode != 0, (mode != 0) ? auto_cmd_nr_i : host_cmd_nr_i,
                 (mode != 0) ? auto_arg_i : host_arg_i, lat);
      auto_req_i = 1'b0;
      if (mode != 2) host_req_i = 1'b0;
      if (mode != 0) play_random(1'b1, auto_cmd_nr_i, auto_rsp_type_i);
      else play_random(1'b0, host_cmd_nr_i, host_rsp_type_i);
      if (mode == 2) begin
        wait_grant(1'b0, host_cmd_nr_i, host_arg_i, lat);
        check_eq("rand_host_after_gap", lat, 0);
        host_req_i = 1'b0;
        play_random(1'b0, host_cmd_nr_i, host_rsp_type_i);
      end
    end

    // Abort while waiting for a response.
    host_cmd_nr_i = 6'd9; host_arg_i = 32'h99; host_rsp_type_i = 2'b10; host_req_i = 1'b1;
    wait_grant(1'b0, 6'd9, 32'h99, lat);
    host_req_i = 1'b0;
    wait_ticks(1);
    tx_done_i = 1'b0;
    wait_ticks(2);
    tx_done_i = 1'b1;
    @(negedge clk);
    check_eq("abort_pre_arm", rsp_arm_o, 1);
    wait_ticks(1 + int'($urandom_range(30)));
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check_eq("abort_arm", rsp_arm_o, 0);
    check_eq("abort_inhibit", cmd_inhibit_o, 0);
    check_eq("abort_outs", outs(), 0);
    saw_done = 1'b0;
    repeat (300) begin
      @(negedge clk);
      saw_done |= cmd_done_o;
    end
    check_eq("abort_no_done", saw_done, 0);

    // Abort beats a grant in the same cycle.
    host_req_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check_eq("abort_blocks_grant", {host_grant_o, cmd_inhibit_o}, 0);
    wait_grant(1'b0, 6'd9, 32'h99, lat);
    check_eq("grant_after_abort", lat, 0);
    host_req_i = 1'b0;
    play_cmd(1'b0, 6'd9, 2'b10, 1, 2, 3, 1'b0, 1'b0, 6'd9);

    // Asynchronous reset during TX.
    host_req_i = 1'b1;
    wait_grant(1'b0, 6'd9, 32'h99, lat);
    host_req_i = 1'b0;
    tx_done_i = 1'b0;
    @(negedge clk);
    wait_ticks(2);
    #3 rst_ni = 1'b0;
    #1 check_eq("async_reset_outs", outs(), 0);
    @(negedge clk);
    tx_done_i = 1'b1;
    rst_ni = 1'b1;
    @(negedge clk);
    check_eq("after_reset_outs", outs(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
